// File: rtl/cascade_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cascade_stage_sequencer
// Description : Runs one detection window through a Haar cascade on a single
//               classifier datapath. For each stage it clears the classifier
//               accumulator and reads the stage descriptor. It then streams
//               that stage's features from the feature ROM, pulsing the
//               classifier enable once per feature, and finally samples the
//               stage pass flag. The window ends at the first failing stage
//               (reject) or after the last stage passes (face).
// Ports       : clk, rst_n        - clock / async active-low reset
//               start, abort      - window control from the scanner
//               busy              - window in progress (any non-IDLE state)
//               stage_rd_en/addr  - stage ROM read; cnt/base return 1 cycle later
//               stage_cnt/base    - feature count / first feature address
//               feat_rd_en/addr   - feature ROM read strobe and address
//               clf_clr, clf_en   - classifier accumulator clear / accumulate
//               stage_status      - classifier stage pass flag
//               result_valid      - 1-cycle result strobe
//               face_detected     - all stages passed (held)
//               reject_stage      - failing stage, NUM_STAGES-1 on face (held)
// Revision    : 1.0 - initial release
// ============================================================================
module cascade_stage_sequencer #(
  parameter int NUM_STAGES = 25,
  parameter int STAGE_AW   = 5,
  parameter int FEAT_AW    = 12,
  parameter int FCNT_W     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                stage_rd_en,
  output logic [STAGE_AW-1:0] stage_addr,
  input  logic [FCNT_W-1:0]   stage_cnt,
  input  logic [FEAT_AW-1:0]  stage_base,
  output logic                feat_rd_en,
  output logic [FEAT_AW-1:0]  feat_addr,
  output logic                clf_clr,
  output logic                clf_en,
  input  logic                stage_status,
  output logic                result_valid,
  output logic                face_detected,
  output logic [STAGE_AW-1:0] reject_stage
);

  localparam logic [STAGE_AW-1:0] c_last_stage = STAGE_AW'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_FEAT  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_EVAL  = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [STAGE_AW-1:0]  r_stage_idx;
  logic [FCNT_W-1:0]    r_cnt;
  logic [FCNT_W-1:0]    r_i;
  logic [FEAT_AW-1:0]   r_base;
  logic [FEAT_AW-1:0]   r_last_addr;
  logic                 r_clf_en;
  logic                 r_face;
  logic [STAGE_AW-1:0]  r_reject;
  logic [FEAT_AW-1:0]   w_feat_addr;
  logic                 w_last_feat;

  // Address arithmetic is FEAT_AW wide so base+i wraps at the top of the ROM.
  assign w_feat_addr = r_base + FEAT_AW'(r_i);
  // Compare against cnt-1 rather than incrementing past cnt, so a full-scale
  // count (all ones) finishes without the index ever overflowing.
  assign w_last_feat = (r_i == (r_cnt - FCNT_W'(1)));

  // Next-state logic; abort overrides every transition outside IDLE.
  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (start) w_next = ST_LOAD;
        ST_LOAD:  w_next = ST_WAIT;
        ST_WAIT:  w_next = (stage_cnt == '0) ? ST_DRAIN : ST_FEAT;
        ST_FEAT:  if (w_last_feat) w_next = ST_DRAIN;
        ST_DRAIN: w_next = ST_EVAL;
        ST_EVAL: begin
          if (!stage_status || (r_stage_idx == c_last_stage)) w_next = ST_DONE;
          else                                                  w_next = ST_LOAD;
        end
        ST_DONE:  w_next = ST_IDLE;
        default:  w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_stage_idx <= '0;
      r_cnt       <= '0;
      r_i         <= '0;
      r_base      <= '0;
      r_last_addr <= '0;
      r_clf_en    <= 1'b0;
      r_face      <= 1'b0;
      r_reject    <= '0;
    end else begin
      r_state  <= w_next;
      // A read issued in the cycle abort arrives never reaches the classifier.
      r_clf_en <= (r_state == ST_FEAT) && !abort;
      if (r_state == ST_FEAT) r_last_addr <= w_feat_addr;
      if (!abort) begin
        case (r_state)
          ST_IDLE: if (start) r_stage_idx <= '0;
          ST_WAIT: begin
            r_cnt  <= stage_cnt;
            r_base <= stage_base;
            r_i    <= '0;
          end
          ST_FEAT: r_i <= r_i + FCNT_W'(1);
          ST_EVAL: begin
            if (!stage_status) begin
              r_face   <= 1'b0;
              r_reject <= r_stage_idx;
            end else if (r_stage_idx == c_last_stage) begin
              r_face   <= 1'b1;
              r_reject <= c_last_stage;
            end else begin
              r_stage_idx <= r_stage_idx + STAGE_AW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy          = (r_state != ST_IDLE);
  assign stage_rd_en   = (r_state == ST_LOAD);
  assign clf_clr       = (r_state == ST_LOAD);
  assign stage_addr    = r_stage_idx;
  assign feat_rd_en    = (r_state == ST_FEAT);
  // Outside FEAT the address bus parks on the last address actually read.
  assign feat_addr     = (r_state == ST_FEAT) ? w_feat_addr : r_last_addr;
  assign clf_en        = r_clf_en;
  assign result_valid  = (r_state == ST_DONE);
  assign face_detected = r_face;
  assign reject_stage  = r_reject;

endmodule
`default_nettype wire

// File: tb/tb_cascade_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cascade_stage_sequencer
// Description : Directed self-checking bench for cascade_stage_sequencer with
//               a two-stage cascade and a small registered stage ROM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cascade_stage_sequencer;

  localparam int NUM_STAGES = 2;
  localparam int STAGE_AW   = 5;
  localparam int FEAT_AW    = 12;
  localparam int FCNT_W     = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic                abort;
  logic                busy;
  logic                stage_rd_en;
  logic [STAGE_AW-1:0] stage_addr;
  logic [FCNT_W-1:0]   stage_cnt;
  logic [FEAT_AW-1:0]  stage_base;
  logic                feat_rd_en;
  logic [FEAT_AW-1:0]  feat_addr;
  logic                clf_clr;
  logic                clf_en;
  logic                stage_status;
  logic                result_valid;
  logic                face_detected;
  logic [STAGE_AW-1:0] reject_stage;

  cascade_stage_sequencer #(
    .NUM_STAGES (NUM_STAGES),
    .STAGE_AW   (STAGE_AW),
    .FEAT_AW    (FEAT_AW),
    .FCNT_W     (FCNT_W)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .busy          (busy),
    .stage_rd_en   (stage_rd_en),
    .stage_addr    (stage_addr),
    .stage_cnt     (stage_cnt),
    .stage_base    (stage_base),
    .feat_rd_en    (feat_rd_en),
    .feat_addr     (feat_addr),
    .clf_clr       (clf_clr),
    .clf_en        (clf_en),
    .stage_status  (stage_status),
    .result_valid  (result_valid),
    .face_detected (face_detected),
    .reject_stage  (reject_stage)
  );

  always #5 clk = ~clk;

  // Stage ROM model: one-cycle read latency.
  logic [FCNT_W-1:0]  cnt_tab  [2];
  logic [FEAT_AW-1:0] base_tab [2];
  always @(posedge clk) begin
    if (stage_rd_en) begin
      stage_cnt  <= cnt_tab[stage_addr[0]];
      stage_base <= base_tab[stage_addr[0]];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-run recordings, indexed by cycle (cycle 0 = cycle start is raised).
  logic [63:0]        en_mask, clr_mask, srd_mask, busy_mask;
  int                 rv_cyc, rv_cnt;
  logic               face_at_rv;
  logic [STAGE_AW-1:0] rej_at_rv;
  logic [FEAT_AW-1:0] fa_q [$];
  logic [FEAT_AW-1:0] fa_all [64];

  task automatic run(input int fail_cyc, input int abort_cyc, input int ncyc, input bit hold_start);
    en_mask = '0; clr_mask = '0; srd_mask = '0; busy_mask = '0;
    rv_cyc = -1; rv_cnt = 0; face_at_rv = 1'bx; rej_at_rv = 'x;
    fa_q.delete();
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      @(negedge clk);
      en_mask[cyc]   = clf_en;
      clr_mask[cyc]  = clf_clr;
      srd_mask[cyc]  = stage_rd_en;
      busy_mask[cyc] = busy;
      fa_all[cyc]    = feat_addr;
      if (feat_rd_en) fa_q.push_back(feat_addr);
      if (result_valid) begin
        rv_cnt++;
        if (rv_cyc < 0) begin
          rv_cyc     = cyc;
          face_at_rv = face_detected;
          rej_at_rv  = reject_stage;
        end
      end
      start        = (cyc == 0) || hold_start;
      stage_status = (cyc != fail_cyc);
      abort        = (cyc == abort_cyc);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; stage_status = 1'b0;
    cnt_tab[0] = 8'd3; cnt_tab[1] = 8'd2;
    base_tab[0] = 12'h100; base_tab[1] = 12'h200;
    repeat (3) @(negedge clk);
    check_eq("reset_busy",   {63'b0, busy}, 64'd0);
    check_eq("reset_strobes", {58'b0, stage_rd_en, feat_rd_en, clf_clr, clf_en, result_valid, face_detected}, 64'd0);
    check_eq("reset_addrs",  {47'b0, feat_addr, stage_addr}, 64'd0);
    check_eq("reset_reject", {59'b0, reject_stage}, 64'd0);
    rst_n = 1'b1;

    // 1: two stages, all pass
    run(-1, -1, 20, 1'b0);
    check_eq("t1_rv_cyc", rv_cyc, 14);
    check_eq("t1_rv_cnt", rv_cnt, 1);
    check_eq("t1_face",   face_at_rv, 1);
    check_eq("t1_reject", rej_at_rv, 1);
    check_eq("t1_clf_en", en_mask, 64'h1870);
    check_eq("t1_clf_clr", clr_mask, 64'h102);
    check_eq("t1_overlap", en_mask & clr_mask, 64'h0);
    check_eq("t1_busy",   busy_mask, 64'h7FFE);
    check_eq("t1_feat_n", fa_q.size(), 5);
    check_eq("t1_feat0",  fa_q[0], 12'h100);
    check_eq("t1_feat3",  fa_q[3], 12'h200);

    // 1b: last stage fails
    run(13, -1, 20, 1'b0);
    check_eq("t1b_rv_cyc", rv_cyc, 14);
    check_eq("t1b_face",   face_at_rv, 0);
    check_eq("t1b_reject", rej_at_rv, 1);

    // 2: stage 0 fails
    run(7, -1, 20, 1'b0);
    check_eq("t2_rv_cyc", rv_cyc, 8);
    check_eq("t2_face",   face_at_rv, 0);
    check_eq("t2_reject", rej_at_rv, 0);
    check_eq("t2_stage_rd", srd_mask, 64'h2);
    check_eq("t2_clf_en", en_mask, 64'h70);
    check_eq("t2_busy",   busy_mask, 64'h1FE);

    // 3: feature address wrap
    cnt_tab[0] = 8'd4; base_tab[0] = 12'hFFE;
    cnt_tab[1] = 8'd1; base_tab[1] = 12'h010;
    run(-1, -1, 20, 1'b0);
    check_eq("t3_feat_n", fa_q.size(), 5);
    check_eq("t3_feat0",  fa_q[0], 12'hFFE);
    check_eq("t3_feat1",  fa_q[1], 12'hFFF);
    check_eq("t3_feat2",  fa_q[2], 12'h000);
    check_eq("t3_feat3",  fa_q[3], 12'h001);
    check_eq("t3_hold",   fa_all[7], 12'h001);
    check_eq("t3_rv_cyc", rv_cyc, 14);

    // 4b: empty stage 0 that fails
    cnt_tab[0] = 8'd0; base_tab[0] = 12'h300;
    cnt_tab[1] = 8'd2; base_tab[1] = 12'h400;
    run(4, -1, 20, 1'b0);
    check_eq("t4b_rv_cyc", rv_cyc, 5);
    check_eq("t4b_face",   face_at_rv, 0);
    check_eq("t4b_feat_n", fa_q.size(), 0);
    check_eq("t4b_clf_en", en_mask, 64'h0);

    // 4a: empty stage 0 that passes
    run(-1, -1, 20, 1'b0);
    check_eq("t4a_rv_cyc", rv_cyc, 11);
    check_eq("t4a_face",   face_at_rv, 1);
    check_eq("t4a_reject", rej_at_rv, 1);
    check_eq("t4a_clf_en", en_mask, 64'h300);
    check_eq("t4a_clf_clr", clr_mask, 64'h22);

    // 5: abort during stage 1 FEAT, then a clean restart
    cnt_tab[0] = 8'd3; base_tab[0] = 12'h100;
    cnt_tab[1] = 8'd2; base_tab[1] = 12'h200;
    run(-1, 10, 20, 1'b0);
    check_eq("t5_rv_cnt", rv_cnt, 0);
    check_eq("t5_busy",   busy_mask, 64'h7FE);
    check_eq("t5_clf_en", en_mask, 64'h70);
    check_eq("t5_face_held", {63'b0, face_detected}, 64'd1);
    check_eq("t5_reject_held", {59'b0, reject_stage}, 64'd1);
    run(-1, -1, 20, 1'b0);
    check_eq("t5_rerun_rv", rv_cyc, 14);
    check_eq("t5_rerun_clr", clr_mask, 64'h102);

    // 6: start held high, reset pulsed mid-FEAT
    @(negedge clk);
    start = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("t6_pre_feat", {63'b0, feat_rd_en}, 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_busy", {63'b0, busy}, 64'd0);
    check_eq("t6_rst_outs", {58'b0, stage_rd_en, feat_rd_en, clf_clr, clf_en, result_valid, face_detected}, 64'd0);
    check_eq("t6_rst_addr", {47'b0, feat_addr, stage_addr}, 64'd0);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    run(-1, -1, 30, 1'b0);
    check_eq("t6_rv_cnt", rv_cnt, 1);
    check_eq("t6_rv_cyc", rv_cyc, 14);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
